switch_box_cfg_loader: RTL



---
 rtl/switch_box_pkg.sv | 20 ++
 rtl/switch_box_cfg_loader_if.sv | 26 ++
 rtl/switch_box_cfg_shreg.sv | 47 ++++
 rtl/switch_box_cfg_loader.sv | 103 ++++++++++
 4 files changed

// File: rtl/switch_box_pkg.sv
// Shared types and constants for the switch box config loader.
// Element c-bit indices name the routing switch each bit controls.
package switch_box_pkg;

  localparam int unsigned SB_ELEM_BITS = 6;

  localparam int unsigned SB_NE = 0;
  localparam int unsigned SB_ES = 1;
  localparam int unsigned SB_SW = 2;
  localparam int unsigned SB_WN = 3;
  localparam int unsigned SB_NS = 4;
  localparam int unsigned SB_EW = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } sb_cfg_state_t;

endpackage

// File: rtl/switch_box_cfg_loader_if.sv
// Serial config handshake plus the committed parallel config bus.
// The master drives frames in; the slave (loader) owns status and c_out.
interface switch_box_cfg_loader_if #(
  parameter int unsigned W = 24
) ();

  logic         cfg_start;
  logic         cfg_valid;
  logic         cfg_in;
  logic         cfg_ready;
  logic         cfg_busy;
  logic         cfg_done;
  logic         cfg_err;
  logic [W-1:0] c_out;

  modport master (
    output cfg_start, cfg_valid, cfg_in,
    input  cfg_ready, cfg_busy, cfg_done, cfg_err, c_out
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_in,
    output cfg_ready, cfg_busy, cfg_done, cfg_err, c_out
  );

endinterface

// File: rtl/switch_box_cfg_shreg.sv
// Shadow shift register, accepted-bit counter and last-bit detect.
// Bits beyond W (e.g. a trailing parity bit) are counted but not shifted in.
module switch_box_cfg_shreg #(
  parameter int unsigned W         = 24,
  parameter int unsigned FrameBits = 24
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         accept_i,
  input  logic         bit_i,
  output logic [W-1:0] shadow_o,
  output logic         last_o
);

  localparam int unsigned CntW = $clog2(W + 2);

  logic [W-1:0]    shadow_d, shadow_q;
  logic [CntW-1:0] count_d, count_q;

  always_comb begin
    shadow_d = shadow_q;
    count_d  = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (accept_i) begin
      count_d = count_q + CntW'(1);
      if (count_q < CntW'(W)) begin
        shadow_d = {bit_i, shadow_q[W-1:1]};
      end
    end
  end

  assign last_o   = accept_i && !clear_i && (count_q == CntW'(FrameBits - 1));
  assign shadow_o = shadow_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q <= '0;
      count_q  <= '0;
    end else begin
      shadow_q <= shadow_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/switch_box_cfg_loader.sv
// Serial-in, atomically committed config loader for a row of switch box elements.
// Optional even-parity frame check is enabled with SWITCH_BOX_CFG_PARITY_EN.
module switch_box_cfg_loader
  import switch_box_pkg::*;
#(
  parameter int unsigned NUM_ELEMS = 4,
  parameter int unsigned ELEM_BITS = SB_ELEM_BITS
) (
  input logic                    clk,
  input logic                    rst,
  switch_box_cfg_loader_if.slave cfg
);

  localparam int unsigned W = NUM_ELEMS * ELEM_BITS;
`ifdef SWITCH_BOX_CFG_PARITY_EN
  localparam int unsigned FrameBits = W + 1;
`else
  localparam int unsigned FrameBits = W;
`endif

  sb_cfg_state_t state_d, state_q;
  logic [W-1:0]  c_out_d, c_out_q;
  logic [W-1:0]  shadow;
  logic          done_d, done_q;
  logic          accept, clear, last, commit_ok;

  assign accept = (state_q == SHIFT) && cfg.cfg_valid && !cfg.cfg_start;
  // A start during COMMIT is ignored, so it must not disturb the counter either.
  assign clear  = cfg.cfg_start && (state_q != COMMIT);

  switch_box_cfg_shreg #(
    .W         (W),
    .FrameBits (FrameBits)
  ) u_shreg (
    .clk_i    (clk),
    .rst_i    (rst),
    .clear_i  (clear),
    .accept_i (accept),
    .bit_i    (cfg.cfg_in),
    .shadow_o (shadow),
    .last_o   (last)
  );

`ifdef SWITCH_BOX_CFG_PARITY_EN
  logic parity_d, parity_q;
  logic err_d, err_q;

  assign parity_d  = last ? cfg.cfg_in : parity_q;
  assign commit_ok = (parity_q == ^shadow);
  assign err_d     = (state_q == COMMIT) && !commit_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      parity_q <= parity_d;
      err_q    <= err_d;
    end
  end

  assign cfg.cfg_err = err_q;
`else
  assign commit_ok   = 1'b1;
  assign cfg.cfg_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    c_out_d = c_out_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE:   if (cfg.cfg_start) state_d = SHIFT;
      SHIFT:  if (last) state_d = COMMIT;
      COMMIT: begin
        state_d = IDLE;
        if (commit_ok) begin
          c_out_d = shadow;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      c_out_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_out_q <= c_out_d;
      done_q  <= done_d;
    end
  end

  assign cfg.cfg_ready = (state_q == SHIFT);
  assign cfg.cfg_busy  = (state_q != IDLE);
  assign cfg.cfg_done  = done_q;
  assign cfg.c_out     = c_out_q;

endmodule
